// File: rtl/bus_pkg.sv
// Shared constants for the data-bus transfer sequencer:
// source codes, destination indices and the source legality check.
package bus_pkg;

  localparam int SELECTOR_WIDTH = 4;

  localparam logic [SELECTOR_WIDTH-1:0] SRC_ZERO   = 4'd0;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_PC     = 4'd1;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_SP     = 4'd2;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_ADD    = 4'd3;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_X      = 4'd4;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_Y      = 4'd5;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_STAT   = 4'd6;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_MEM    = 4'd7;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_IMM    = 4'd8;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_FETCH  = 4'd9;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_DECODE = 4'd10;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_ALU    = 4'd11;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_RSV_C  = 4'd12;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_ONES   = 4'd13;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_RSV_E  = 4'd14;
  localparam logic [SELECTOR_WIDTH-1:0] SRC_RSV_F  = 4'd15;

  localparam int DST_PC     = 0;
  localparam int DST_SP     = 1;
  localparam int DST_ADD    = 2;
  localparam int DST_X      = 3;
  localparam int DST_Y      = 4;
  localparam int DST_STAT   = 5;
  localparam int DST_MEM    = 6;
  localparam int DST_FETCH  = 7;
  localparam int DST_DECODE = 8;
  localparam int DST_ALU0   = 9;
  localparam int DST_ALU1   = 10;

  function automatic logic src_legal(
    input logic [SELECTOR_WIDTH-1:0] src
  );
    return !(src inside {SRC_RSV_C, SRC_RSV_E, SRC_RSV_F});
  endfunction

endpackage

// File: rtl/bus_req_fifo.sv
// Synchronous request FIFO with exact occupancy count.
// Pointers wrap modulo DEPTH, which must be a power of two.
module bus_req_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Queues bus transfers, drives mux selectors, then pulses load enables.
// Optional BUS_XFER_STATS_EN adds saturating xfer/err counters.
module bus_xfer_sequencer
  import bus_pkg::*;
#(
  parameter int NUM_DEST   = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [SELECTOR_WIDTH-1:0]            req_src,
  input  logic [NUM_DEST-1:0]                  req_dst_mask,
  output logic [NUM_DEST*SELECTOR_WIDTH-1:0]   sel_bus,
  output logic [NUM_DEST-1:0]                  load_en,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 err_illegal
`ifdef BUS_XFER_STATS_EN
  ,
  output logic [15:0]                          xfer_count,
  output logic [7:0]                           err_count
`endif
);

  localparam int SW = SELECTOR_WIDTH;
  localparam int FW = SW + NUM_DEST;

  logic                full;
  logic                empty;
  logic                accept;
  logic                legal;
  logic                push;
  logic                pop;
  logic [FW-1:0]       head;

  logic                s_valid;
  logic [SW-1:0]       s_src;
  logic [NUM_DEST-1:0] s_mask;
  logic                l_valid;
  logic [NUM_DEST-1:0] l_mask;

  // flush blocks acceptance so nothing slips in behind the discard
  assign req_ready = !full && !flush;
  assign accept    = req_valid && req_ready;
  assign legal     = src_legal(req_src) && (|req_dst_mask);
  assign push      = accept && legal;
  assign pop       = !empty && !flush;

  bus_req_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({req_src, req_dst_mask}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid     <= 1'b0;
      s_src       <= '0;
      s_mask      <= '0;
      l_valid     <= 1'b0;
      l_mask      <= '0;
      err_illegal <= 1'b0;
    end else begin
      s_valid     <= pop;
      if (pop) {s_src, s_mask} <= head;
      l_valid     <= s_valid && !flush;
      if (s_valid) l_mask <= s_mask;
      err_illegal <= accept && !legal;
    end
  end

  always_comb begin
    sel_bus = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      if (s_valid && s_mask[d]) sel_bus[d*SW +: SW] = s_src;
    end
  end

  assign load_en = l_valid ? l_mask : '0;
  assign busy    = !empty || s_valid || l_valid;

`ifdef BUS_XFER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      if (l_valid && xfer_count != 16'hFFFF)
        xfer_count <= xfer_count + 16'd1;
      if (err_illegal && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed plus random bench for bus_xfer_sequencer against a
// transfer-timeline model; BUS_XFER_STATS_EN also checks counters.
module tb_bus_xfer_sequencer;

  localparam int SW = 4;
  localparam int ND = 11;
  localparam int FD = 4;
  localparam int CW = $clog2(FD+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [SW-1:0]     req_src;
  logic [ND-1:0]     req_dst_mask;
  logic [ND*SW-1:0]  sel_bus;
  logic [ND-1:0]     load_en;
  logic              busy;
  logic [CW-1:0]     fifo_count;
  logic              err_illegal;
`ifdef BUS_XFER_STATS_EN
  logic [15:0]       xfer_count;
  logic [7:0]        err_count;
  int                exp_xfer;
  int                exp_errc;
`endif

  bus_xfer_sequencer #(
    .NUM_DEST   (ND),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_dst_mask (req_dst_mask),
    .sel_bus      (sel_bus),
    .load_en      (load_en),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .err_illegal  (err_illegal)
`ifdef BUS_XFER_STATS_EN
    ,
    .xfer_count   (xfer_count),
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  // An accepted transfer from cycle c sits in the queue during c+1,
  // drives selectors during c+2 and strobes loads during c+3.
  typedef struct {
    int            cyc;
    logic [SW-1:0] src;
    logic [ND-1:0] mask;
  } xfer_t;

  xfer_t q[$];
  int    err_q[$];
  int    cyc;
  int    n_tests;
  int    n_fail;
  logic [ND-1:0] last_load;

  function automatic bit is_legal(logic [SW-1:0] s, logic [ND-1:0] m);
    return (s != 4'd12) && (s != 4'd14) && (s != 4'd15) && (m != '0);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic [ND*SW-1:0] e_sel;
    logic [ND-1:0]    e_load;
    int               e_cnt;
    bit               e_busy;
    bit               e_err;
    xfer_t            nq[$];
    int               ne[$];
    @(negedge clk);
    e_sel  = '0;
    e_load = '0;
    e_cnt  = 0;
    e_busy = 0;
    e_err  = 0;
    foreach (q[i]) begin
      if (q[i].cyc + 1 == cyc) e_cnt++;
      if (q[i].cyc + 2 == cyc)
        for (int d = 0; d < ND; d++)
          if (q[i].mask[d]) e_sel[d*SW +: SW] = q[i].src;
      if (q[i].cyc + 3 == cyc) e_load = q[i].mask;
      if (cyc >= q[i].cyc + 1 && cyc <= q[i].cyc + 3) e_busy = 1;
    end
    foreach (err_q[i]) if (err_q[i] == cyc) e_err = 1;
    chk("sel_bus", 64'(sel_bus), 64'(e_sel));
    chk("load_en", 64'(load_en), 64'(e_load));
    chk("fifo_count", 64'(fifo_count), 64'(e_cnt));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("err_illegal", 64'(err_illegal), 64'(e_err));
    chk("req_ready", 64'(req_ready), 64'(!flush));
    last_load = load_en;
`ifdef BUS_XFER_STATS_EN
    chk("xfer_count", 64'(xfer_count), 64'(exp_xfer));
    chk("err_count", 64'(err_count), 64'(exp_errc));
    if (!reset) begin
      if (e_load != '0 && exp_xfer < 16'hFFFF) exp_xfer++;
      if (e_err && exp_errc < 8'hFF) exp_errc++;
    end
`endif
    if (!reset) begin
      if (flush) begin
        foreach (q[i]) if (q[i].cyc + 3 <= cyc) nq.push_back(q[i]);
        q = nq;
        nq = {};
      end else if (req_valid) begin
        if (is_legal(req_src, req_dst_mask))
          q.push_back('{cyc, req_src, req_dst_mask});
        else
          err_q.push_back(cyc + 1);
      end
    end
    foreach (q[i]) if (q[i].cyc + 3 >= cyc) nq.push_back(q[i]);
    q = nq;
    foreach (err_q[i]) if (err_q[i] > cyc) ne.push_back(err_q[i]);
    err_q = ne;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(bit v, logic [SW-1:0] s, logic [ND-1:0] m);
    req_valid    = v;
    req_src      = s;
    req_dst_mask = m;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    reset   = 1'b1;
    flush   = 1'b0;
    req_valid    = 1'b0;
    req_src      = '0;
    req_dst_mask = '0;
`ifdef BUS_XFER_STATS_EN
    exp_xfer = 0;
    exp_errc = 0;
`endif
    idle(2);
    reset = 1'b0;
    idle(1);

    // single transfer X -> ADD
    drive(1'b1, 4'd4, 11'b000_0000_0100);
    idle(2);
    chk("t1_sel_add", 64'(sel_bus[2*SW +: SW]), 64'd0);
    idle(1);
    chk("t1_load", 64'(last_load), 64'h004);
    idle(2);

    // broadcast then back-to-back
    drive(1'b1, 4'd1, 11'b000_0000_0011);
    drive(1'b1, 4'd11, 11'b010_0000_0000);
    idle(5);

    // flood: six requests in six cycles
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, SW'(i % 11), ND'(1 << i));
      chk("t3_count_le_depth", 64'(fifo_count <= CW'(FD)), 64'd1);
    end
    idle(4);

    // illegal source and empty mask
    drive(1'b1, 4'd12, 11'b000_0000_1000);
    drive(1'b1, 4'd4, 11'b000_0000_0000);
    idle(3);

    // flush with transfers spread across the pipeline
    drive(1'b1, 4'd2, 11'b000_0000_0001);
    drive(1'b1, 4'd3, 11'b000_0000_0010);
    drive(1'b1, 4'd5, 11'b000_0000_0100);
    drive(1'b1, 4'd6, 11'b000_0000_1000);
    flush = 1'b1;
    drive(1'b1, 4'd7, 11'b000_0001_0000);
    flush = 1'b0;
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0,
            SW'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? '0 : ND'($urandom));
    end
    flush = 1'b0;
    idle(5);

    // reset while a load strobe is active
    drive(1'b1, 4'd13, 11'b100_0000_0001);
    idle(2);
    chk("t6_load_before", 64'(load_en), 64'h401);
    reset = 1'b1;
    #1;
    chk("t6_load_async", 64'(load_en), 64'h000);
    chk("t6_busy_async", 64'(busy), 64'd0);
    q     = {};
    err_q = {};
`ifdef BUS_XFER_STATS_EN
    chk("t6_xfer_async", 64'(xfer_count), 64'd0);
    exp_xfer = 0;
    exp_errc = 0;
`endif
    idle(2);
    reset = 1'b0;
    drive(1'b1, 4'd8, 11'b000_1000_0000);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
